// File: rtl/mem_bus_arbiter.sv
// Two-requester (cpu / dma) arbiter for a single memory port with burst-limited
// round-robin ownership and tagged routing of pipelined read data.
module mem_bus_arbiter #(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned MEM_LAT   = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_rw,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    input  logic          dma_req,
    input  logic          dma_rw,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner,
    output logic          busy
);

    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_CPU = 2'd1,
        OWN_DMA = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [CW-1:0]        r_beat_cnt;
    logic [CW-1:0]        w_next_cnt;
    logic                 r_last_owner;   // 1 = dma
    logic                 w_next_last;
    logic [MEM_LAT-1:0]   r_tag_v;
    logic [MEM_LAT-1:0]   r_tag_p;

    logic                 w_own_cpu;
    logic                 w_own_dma;
    logic                 w_beat;
    logic                 w_last_beat;

    always_comb begin
        w_own_cpu   = (r_state == OWN_CPU);
        w_own_dma   = (r_state == OWN_DMA);
        w_beat      = (w_own_cpu & cpu_req) | (w_own_dma & dma_req);
        w_last_beat = (r_beat_cnt == CW'(MAX_BURST - 1));
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_beat_cnt;
        w_next_last  = r_last_owner;
        case (r_state)
            IDLE: begin
                w_next_cnt = '0;
                // Ties go to whichever port did not own the bus most recently.
                if (cpu_req && dma_req) begin
                    w_next_state = r_last_owner ? OWN_CPU : OWN_DMA;
                end else if (cpu_req) begin
                    w_next_state = OWN_CPU;
                end else if (dma_req) begin
                    w_next_state = OWN_DMA;
                end
            end
            OWN_CPU: begin
                if (!cpu_req) begin
                    w_next_state = dma_req ? OWN_DMA : IDLE;
                    w_next_cnt   = '0;
                    w_next_last  = 1'b0;
                end else if (w_last_beat) begin
                    w_next_cnt = '0;
                    if (dma_req) begin
                        w_next_state = OWN_DMA;
                        w_next_last  = 1'b0;
                    end
                end else begin
                    w_next_cnt = r_beat_cnt + CW'(1);
                end
            end
            OWN_DMA: begin
                if (!dma_req) begin
                    w_next_state = cpu_req ? OWN_CPU : IDLE;
                    w_next_cnt   = '0;
                    w_next_last  = 1'b1;
                end else if (w_last_beat) begin
                    w_next_cnt = '0;
                    if (cpu_req) begin
                        w_next_state = OWN_CPU;
                        w_next_last  = 1'b1;
                    end
                end else begin
                    w_next_cnt = r_beat_cnt + CW'(1);
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_comb begin
        mem_en    = w_beat;
        mem_rw    = 1'b1;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_own_cpu && cpu_req) begin
            mem_rw    = cpu_rw;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (w_own_dma && dma_req) begin
            mem_rw    = dma_rw;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
        cpu_gnt    = w_own_cpu;
        dma_gnt    = w_own_dma;
        owner      = w_own_dma;
        busy       = (r_state != IDLE);
        rdata      = mem_rdata;
        cpu_rvalid = r_tag_v[MEM_LAT-1] & ~r_tag_p[MEM_LAT-1];
        dma_rvalid = r_tag_v[MEM_LAT-1] &  r_tag_p[MEM_LAT-1];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_beat_cnt   <= '0;
            r_last_owner <= 1'b1;
        end else begin
            r_state      <= w_next_state;
            r_beat_cnt   <= w_next_cnt;
            r_last_owner <= w_next_last;
        end
    end

    // Tag pipeline runs independently of ownership so reads survive a hand-off.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tag_v <= '0;
            r_tag_p <= '0;
        end else begin
            r_tag_v[0] <= w_beat & mem_rw;
            r_tag_p[0] <= w_own_dma;
            for (int unsigned i = 1; i < MEM_LAT; i++) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_p[i] <= r_tag_p[i-1];
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed ownership/burst sequences
// plus a read-return scoreboard fed at stimulus time.
module tb_mem_bus_arbiter;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned BURST = 8;
    localparam int unsigned LAT   = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_rw, dma_req, dma_rw;
    logic [AW-1:0] cpu_addr, dma_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata;
    logic          cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_rw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          owner, busy;

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
    } rd_exp_t;

    rd_exp_t sb[$];
    int      n_checks = 0;
    int      n_pass   = 0;

    always #5 clock = ~clock;

    mem_bus_arbiter #(
        .AW(AW),
        .DW(DW),
        .MAX_BURST(BURST),
        .MEM_LAT(LAT)
    ) u_dut (
        .clock(clock),
        .reset(reset),
        .cpu_req(cpu_req),
        .cpu_rw(cpu_rw),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt),
        .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req),
        .dma_rw(dma_rw),
        .dma_addr(dma_addr),
        .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt),
        .dma_rvalid(dma_rvalid),
        .rdata(rdata),
        .mem_en(mem_en),
        .mem_rw(mem_rw),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .owner(owner),
        .busy(busy)
    );

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction

    // Memory macro model: data for the address presented LAT edges earlier.
    logic [DW-1:0] m_pipe [LAT];
    always @(posedge clock) begin
        m_pipe[0] <= mem_fn(mem_addr);
        for (int i = 1; i < LAT; i++) m_pipe[i] <= m_pipe[i-1];
    end
    assign mem_rdata = m_pipe[LAT-1];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic push_exp(input logic port, input logic [DW-1:0] data);
        rd_exp_t e;
        e.port = port;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_cpu(input logic req, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req = req; cpu_rw = rw; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dma(input logic req, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        dma_req = req; dma_rw = rw; dma_addr = a; dma_wdata = d;
    endtask

    always @(negedge clock) begin : sb_monitor
        rd_exp_t e;
        if (cpu_rvalid || dma_rvalid) begin
            if (sb.size() == 0) begin
                check_eq("rv_unexp", {cpu_rvalid, dma_rvalid}, 2'b00);
            end else begin
                e = sb.pop_front();
                check_eq("rv_port", {cpu_rvalid, dma_rvalid}, e.port ? 2'b01 : 2'b10);
                check_eq("rv_data", rdata, e.data);
            end
        end
    end

    initial begin
        reset = 1'b1;
        set_cpu(0, 0, '0, '0);
        set_dma(0, 0, '0, '0);
        #1 reset = 1'b0;
        step();
        step();
        check_eq("rst_ctl", {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_en, mem_rw, owner, busy}, 8'b0000_0100);
        check_eq("rst_bus", {mem_addr, mem_wdata}, 64'h0);

        // Tie immediately after reset release: cpu wins, then direct hand-off.
        reset = 1'b1;
        set_cpu(1, 0, 32'h100, 32'hC0);
        set_dma(1, 0, 32'h200, 32'h12345678);
        #1 check_eq("tie_wait", {cpu_gnt, dma_gnt, busy}, 3'b000);
        step();
        check_eq("tie1_gnt", {cpu_gnt, dma_gnt, owner, busy}, 4'b1001);
        check_eq("tie1_beat", {mem_en, mem_rw}, 2'b10);
        check_eq("tie1_bus", {mem_addr, mem_wdata}, {32'h100, 32'hC0});
        step();
        cpu_req = 1'b0;
        #1 check_eq("drop_bus", {cpu_gnt, mem_en, mem_rw}, 3'b101);
        check_eq("drop_addr", mem_addr, 32'h0);
        step();
        check_eq("handoff", {cpu_gnt, dma_gnt, owner, busy}, 4'b0111);
        check_eq("wr_beat", {mem_en, mem_rw}, 2'b10);
        check_eq("wr_bus", {mem_addr, mem_wdata}, {32'h200, 32'h12345678});
        step();
        dma_req = 1'b0;
        #1 check_eq("wr_done", mem_en, 1'b0);
        step();
        check_eq("idle_after", {busy, cpu_gnt, dma_gnt}, 3'b000);
        for (int i = 0; i < LAT; i++) begin
            check_eq("wr_no_rv", {cpu_rvalid, dma_rvalid}, 2'b00);
            step();
        end

        // Single cpu read from IDLE.
        set_cpu(1, 1, 32'h10, '0);
        #1 check_eq("rd_gnt_lat", cpu_gnt, 1'b0);
        step();
        check_eq("rd_gnt", {cpu_gnt, mem_en, mem_rw}, 3'b111);
        check_eq("rd_addr", mem_addr, 32'h10);
        push_exp(1'b0, 32'hDEADBEEF);
        step();
        cpu_req = 1'b0;
        step();
        check_eq("rd_rv_early", {cpu_rvalid, dma_rvalid, busy}, 3'b000);
        repeat (LAT - 2) step();
        check_eq("rd_rv", {cpu_rvalid, dma_rvalid}, 2'b10);
        check_eq("rd_data", rdata, 32'hDEADBEEF);
        step();
        check_eq("rd_rv_pulse", {cpu_rvalid, dma_rvalid}, 2'b00);

        // cpu owned last, so this tie goes to dma; both held to exercise the burst limit.
        set_cpu(1, 0, 32'h400, 32'hA);
        set_dma(1, 0, 32'h500, 32'hB);
        step();
        for (int i = 0; i < BURST; i++) begin
            check_eq("burst_dma", {cpu_gnt, dma_gnt, mem_en}, 3'b011);
            step();
        end
        check_eq("burst_sw_cpu", {cpu_gnt, dma_gnt}, 2'b10);
        for (int i = 0; i < BURST; i++) begin
            check_eq("burst_cpu", {cpu_gnt, dma_gnt, mem_en}, 3'b101);
            step();
        end
        check_eq("burst_sw_dma", {cpu_gnt, dma_gnt}, 2'b01);
        dma_req = 1'b0;
        cpu_rw  = 1'b1;
        #1 check_eq("dma_drop", mem_en, 1'b0);
        step();
        for (int i = 0; i < 20; i++) begin
            cpu_addr = 32'h1000 + 32'(4 * i);
            #1 check_eq("long_cpu", {cpu_gnt, dma_gnt, mem_en, mem_rw}, 4'b1011);
            check_eq("long_addr", mem_addr, cpu_addr);
            push_exp(1'b0, mem_fn(cpu_addr));
            step();
        end
        cpu_req = 1'b0;
        step();
        check_eq("long_idle", busy, 1'b0);
        repeat (LAT + 1) step();

        // cpu read, then ownership moves to dma while the read is in flight.
        set_cpu(1, 1, 32'h20, '0);
        step();
        set_dma(1, 1, 32'h300, '0);
        #1 check_eq("xs_cpu", {cpu_gnt, mem_en, mem_rw}, 3'b111);
        push_exp(1'b0, mem_fn(32'h20));
        step();
        cpu_req = 1'b0;
        step();
        check_eq("xs_dma_gnt", {cpu_gnt, dma_gnt, mem_en}, 3'b011);
        check_eq("xs_dma_addr", mem_addr, 32'h300);
        step();
        check_eq("xs_rv", {cpu_rvalid, dma_rvalid, dma_gnt}, 3'b101);
        check_eq("xs_data", rdata, mem_fn(32'h20));
        dma_addr = 32'h304;
        step();

        // Two dma reads now in flight; asynchronous reset must cancel them.
        #3 reset = 1'b0;
        #1 check_eq("rst_mid", {cpu_gnt, dma_gnt, mem_en, busy, cpu_rvalid, dma_rvalid}, 6'b0);
        check_eq("rst_mid_rw", mem_rw, 1'b1);
        dma_req = 1'b0;
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < LAT + 3; i++) begin
            check_eq("post_rst", {busy, cpu_rvalid, dma_rvalid}, 3'b000);
            step();
        end

        check_eq("sb_empty", 64'(sb.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 32-bit memory port between two requesters: the cpu (instruction fetch and load/store) and a dma/loader port used for program load and bulk copies.
- Owns ownership sequencing, per-owner burst limiting with round-robin fairness, and routing of read data back to the requester that issued the read.
- Sits between the cpu address/data/rw outputs and the memory macro.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_BURST, 8, max consecutive accepted beats per ownership period while the other requester is waiting (range 1..31).
- MEM_LAT, 1, cycles from accepted read beat to mem_rdata valid (range 1..4).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted); release is synchronised externally.
- cpu_req  in  1  cpu requests a beat; addr/rw/wdata stable while high.
- cpu_rw  in  1  1 = read, 0 = write.
- cpu_addr  in  AW  beat address.
- cpu_wdata  in  DW  write data.
- cpu_gnt  out  1  cpu owns the bus.
- cpu_rvalid  out  1  read data for a cpu read is on rdata.
- dma_req, dma_rw, dma_addr, dma_wdata, dma_gnt, dma_rvalid: same as the cpu_* ports, for the dma port.
- rdata  out  DW  mem_rdata passthrough to both requesters.
- mem_en  out  1  memory beat strobe.
- mem_rw  out  1  1 = read, 0 = write.
- mem_addr  out  AW  to memory.
- mem_wdata  out  DW  to memory.
- mem_rdata  in  DW  from memory, MEM_LAT cycles after a read beat.
- owner  out  1  0 = cpu, 1 = dma; valid only while busy.
- busy  out  1  state != IDLE.

Behaviour:
- FSM states: IDLE, OWN_CPU, OWN_DMA. State is registered. gnt outputs decode state only (cpu_gnt = OWN_CPU, dma_gnt = OWN_DMA).
- Beat: a rising edge with the owner's req = 1 and gnt = 1. mem_en = owner_req & gnt (combinational). mem_rw/addr/wdata mux the owner's signals. When no beat is in progress, mem_addr/mem_wdata are 0 and mem_rw is 1.
- IDLE transitions:
  - Only cpu_req set: go to OWN_CPU.
  - Only dma_req set: go to OWN_DMA.
  - Both set: the port that is not last_owner wins. last_owner resets to dma, so the cpu wins the first tie.
- Grant latency: a req sampled at edge k in IDLE gives gnt high after edge k; the first beat is accepted at edge k+1.
- In OWN_x, beat_cnt increments on each beat.
- Hand-off from OWN_x, evaluated at each edge:
  - x_req = 0 and the other port is requesting: switch directly to the other OWN state, no idle bubble.
  - x_req = 0 and the other port is idle: go to IDLE.
  - Beat with beat_cnt+1 == MAX_BURST and the other port requesting: switch to the other OWN state after this beat.
  - Beat with beat_cnt+1 == MAX_BURST and the other port idle: stay, and clear beat_cnt to 0.
- beat_cnt clears on every ownership change. last_owner updates whenever an OWN state is left.
- Read return: each read beat pushes a tag {valid, port} into a MEM_LAT-deep shift register. At the tail, cpu_rvalid or dma_rvalid pulses for one cycle, aligned with mem_rdata. Reads stay pipelined across an ownership switch, so a dma rvalid may occur while the cpu owns the bus.
- Writes generate no rvalid.
- A requester dropping req mid-burst ends its ownership; in-flight reads still return.
- Reset (async, reset = 0):
  - state IDLE, beat_cnt 0, last_owner dma, tag pipeline cleared.
  - All outputs 0 except mem_rw = 1.
  - Reads in flight at reset never produce rvalid.
- rdata always equals mem_rdata; consumers qualify it with their own rvalid.

Test Plan:
- Single read: cpu_req=1, rw=1, addr=0x10 from IDLE (MEM_LAT=1, mem returns 0xDEADBEEF) -> cpu_gnt high 1 cycle after the req edge; mem_en/addr=0x10 on the next edge; cpu_rvalid=1 with rdata=0xDEADBEEF one cycle after that; dma_rvalid stays 0.
- Tie at reset: both req=1 in first cycle after reset release -> OWN_CPU first. Drop cpu_req after 1 beat -> OWN_DMA the next cycle with no IDLE cycle between. Next tie from IDLE -> dma wins.
- Burst limit: cpu_req held continuously, dma_req held, MAX_BURST=8 -> exactly 8 cpu beats, then dma_gnt. With dma_req=0, cpu gets 20 uninterrupted beats.
- Cross-switch read return: MEM_LAT=3, cpu read beat at edge k, then ownership moves to dma at edge k+1 -> cpu_rvalid pulses at edge k+3, dma_gnt=1, dma_rvalid=0 that cycle.
- Write beat: dma_rw=0, addr=0x200, wdata=0x12345678 -> one mem_en pulse with mem_rw=0 and matching addr/data; no rvalid on either port.
- Reset mid-burst: reset=0 asynchronously during OWN_DMA with 2 reads in flight (MEM_LAT=3) -> gnt/mem_en drop immediately; no rvalid after reset release; busy=0 until the next req.
